// File: rtl/aud_pkg.sv
// aud_pkg: shared state encoding and widths for the audio recorder/player datapath
package aud_pkg;
  localparam int I2S_BITS = 16;
  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SKIP  = 3'd2,
    S_SHIFT = 3'd3,
    S_WRITE = 3'd4,
    S_PAUSE = 3'd5
  } state_t;
endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: synchronises I2S inputs and detects bclk rising and lrc falling edges
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bclk,
  input  logic i_lrc,
  input  logic i_dat,
  output logic sync_dat,
  output logic bclk_rise,
  output logic lrc_fall
);
  logic [STAGES-1:0] bs, ls, ds;
  logic pb, pl;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      bs <= '0;
      ls <= '0;
      ds <= '0;
      pb <= 1'b0;
      pl <= 1'b0;
    end else begin
      bs <= {bs[STAGES-2:0], i_bclk};
      ls <= {ls[STAGES-2:0], i_lrc};
      ds <= {ds[STAGES-2:0], i_dat};
      pb <= bs[STAGES-1];
      pl <= ls[STAGES-1];
    end
  assign sync_dat = ds[STAGES-1];
  assign bclk_rise = bs[STAGES-1] & ~pb;
  assign lrc_fall = ~ls[STAGES-1] & pl;
endmodule

// File: rtl/aud_recorder.sv
// aud_recorder: captures I2S left-channel samples and issues SRAM write strobes
module aud_recorder
  import aud_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bclk,
  input  logic              i_lrc,
  input  logic              i_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr,
  output logic [ADDR_W:0]   o_len,
  output logic              o_recording,
  output logic              o_full
);
  localparam int BW = $clog2(I2S_BITS);
  state_t state;
  logic sync_dat, bclk_rise, lrc_fall;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0] len;
  logic [DATA_W-2:0] sreg;
  logic [DATA_W-1:0] data;
  logic [BW-1:0] bits;
  logic full;
  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_bclk(i_bclk),
    .i_lrc(i_lrc),
    .i_dat(i_adcdat),
    .sync_dat(sync_dat),
    .bclk_rise(bclk_rise),
    .lrc_fall(lrc_fall)
  );
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= S_IDLE;
      cnt <= '0;
      len <= '0;
      full <= 1'b0;
      sreg <= '0;
      data <= '0;
      bits <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (i_start & ~i_stop & ~i_pause) begin
            cnt <= '0;
            len <= '0;
            full <= 1'b0;
            state <= S_WAIT;
          end
        S_WAIT: state <= i_stop ? S_IDLE : i_pause ? S_PAUSE : lrc_fall ? S_SKIP : S_WAIT;
        S_SKIP: begin
          bits <= '0;
          state <= i_stop ? S_IDLE : i_pause ? S_PAUSE : bclk_rise ? S_SHIFT : S_SKIP;
        end
        S_SHIFT:
          if (i_stop | i_pause)
            state <= i_stop ? S_IDLE : S_PAUSE;
          else if (bclk_rise) begin
            sreg <= {sreg[DATA_W-3:0], sync_dat};
            bits <= bits + 1'b1;
            if (bits == BW'(I2S_BITS - 1)) begin
              data <= {sreg, sync_dat};
              state <= S_WRITE;
            end
          end
        S_WRITE: begin
          len <= len + 1'b1;
          if (cnt == MAX_ADDR) begin
            full <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            state <= i_stop ? S_IDLE : i_pause ? S_PAUSE : S_WAIT;
          end
        end
        S_PAUSE: state <= i_stop ? S_IDLE : i_start ? S_WAIT : S_PAUSE;
        default: state <= S_IDLE;
      endcase
    end
  assign o_wr = state == S_WRITE;
  assign o_address = cnt;
  assign o_data = data;
  assign o_len = len;
  assign o_full = full;
  assign o_recording = state inside {S_WAIT, S_SKIP, S_SHIFT, S_WRITE};
endmodule

// File: tb/tb_aud_recorder.sv
// tb_aud_recorder: directed I2S frames with table-driven and hand-written checks
module tb_aud_recorder;
  logic clk = 0, rst = 1, bclk = 1, lrc = 1, dat = 0;
  logic start = 0, pause = 0, stop = 0, start2 = 0;
  logic [19:0] addr, addr2;
  logic [15:0] data, data2;
  logic wr, wr2, rec, rec2, full, full2;
  logic [20:0] len, len2;
  int checks = 0, failures = 0;
  logic [19:0] wa[$], wa2[$];
  logic [15:0] wd[$], wd2[$];
  always #5 clk = ~clk;
  aud_recorder dut (
    .i_clk(clk), .i_rst(rst), .i_bclk(bclk), .i_lrc(lrc), .i_adcdat(dat),
    .i_start(start), .i_pause(pause), .i_stop(stop),
    .o_address(addr), .o_data(data), .o_wr(wr), .o_len(len),
    .o_recording(rec), .o_full(full)
  );
  aud_recorder #(.MAX_ADDR(20'd3)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_bclk(bclk), .i_lrc(lrc), .i_adcdat(dat),
    .i_start(start2), .i_pause(pause), .i_stop(stop),
    .o_address(addr2), .o_data(data2), .o_wr(wr2), .o_len(len2),
    .o_recording(rec2), .o_full(full2)
  );
  always @(negedge clk) begin
    if (wr) begin
      wa.push_back(addr);
      wd.push_back(data);
    end
    if (wr2) begin
      wa2.push_back(addr2);
      wd2.push_back(data2);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic slot_bit(input logic [15:0] w, input int k);
    return k == 0 ? ~w[15] : k <= 16 ? w[16-k] : 1'b1;
  endfunction
  task automatic pulse(input logic [3:0] c);
    @(negedge clk);
    {rst, stop, pause, start} = c;
    @(negedge clk);
    {rst, stop, pause, start} = 4'b0;
  endtask
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int ctl_k, input logic [3:0] ctl);
    for (int h = 0; h < 2; h++)
      for (int k = 0; k < 32; k++) begin
        @(negedge clk);
        bclk = 0;
        lrc = h[0];
        dat = slot_bit(h == 0 ? l : r, k);
        repeat (3) @(negedge clk);
        bclk = 1;
        if (h == 0 && k == ctl_k) {rst, stop, pause, start} = ctl;
        @(negedge clk);
        if (h == 0 && k == ctl_k && ctl[3]) begin
          chk("rst_wr", 32'(wr), 0);
          chk("rst_addr", 32'(addr), 0);
          chk("rst_data", 32'(data), 0);
          chk("rst_len", 32'(len), 0);
          chk("rst_full", 32'(full), 0);
          chk("rst_rec", 32'(rec), 0);
        end
        {rst, stop, pause, start} = 4'b0;
        repeat (2) @(negedge clk);
      end
  endtask
  typedef struct {
    logic stp;
    logic sta;
    logic [15:0] l;
    logic [15:0] r;
    int nw;
    logic [19:0] a;
    logic [15:0] d;
    logic [20:0] n;
  } vec_t;
  vec_t vt[5];
  int n0;
  initial begin
    vt[0] = '{1'b0, 1'b1, 16'hA5C3, 16'hFFFF, 1, 20'd0, 16'hA5C3, 21'd1};
    vt[1] = '{1'b1, 1'b1, 16'h0001, 16'h0000, 1, 20'd0, 16'h0001, 21'd1};
    vt[2] = '{1'b0, 1'b0, 16'h8000, 16'hFFFF, 1, 20'd1, 16'h8000, 21'd2};
    vt[3] = '{1'b0, 1'b0, 16'h7FFF, 16'h0000, 1, 20'd2, 16'h7FFF, 21'd3};
    vt[4] = '{1'b0, 1'b1, 16'h5A5A, 16'hFFFF, 1, 20'd3, 16'h5A5A, 21'd4};
    repeat (4) @(negedge clk);
    rst = 0;
    chk("reset_addr", 32'(addr), 0);
    chk("reset_data", 32'(data), 0);
    chk("reset_wr", 32'(wr), 0);
    chk("reset_len", 32'(len), 0);
    chk("reset_rec", 32'(rec), 0);
    chk("reset_full", 32'(full), 0);
    for (int i = 0; i < 5; i++) begin
      if (vt[i].stp) pulse(4'b0100);
      if (vt[i].sta) pulse(4'b0001);
      n0 = wa.size();
      send_frame(vt[i].l, vt[i].r, -1, 4'b0);
      chk($sformatf("v%0d_nwr", i), 32'(wa.size() - n0), 32'(vt[i].nw));
      if (wa.size() > n0) begin
        chk($sformatf("v%0d_addr", i), 32'(wa[wa.size()-1]), 32'(vt[i].a));
        chk($sformatf("v%0d_data", i), 32'(wd[wd.size()-1]), 32'(vt[i].d));
      end
      chk($sformatf("v%0d_len", i), 32'(len), 32'(vt[i].n));
      chk($sformatf("v%0d_rec", i), 32'(rec), 1);
    end
    n0 = wa.size();
    send_frame(16'h1111, 16'h0000, 7, 4'b0010);
    chk("pause_nwr", 32'(wa.size() - n0), 0);
    chk("pause_rec", 32'(rec), 0);
    chk("pause_len", 32'(len), 4);
    pulse(4'b0001);
    send_frame(16'h1234, 16'hFFFF, -1, 4'b0);
    chk("resume_nwr", 32'(wa.size() - n0), 1);
    chk("resume_addr", 32'(wa[wa.size()-1]), 4);
    chk("resume_data", 32'(wd[wd.size()-1]), 32'h1234);
    chk("resume_len", 32'(len), 5);
    pulse(4'b0100);
    chk("stop_rec", 32'(rec), 0);
    chk("stop_len", 32'(len), 5);
    pulse(4'b0101);
    chk("startstop_rec", 32'(rec), 0);
    chk("startstop_len", 32'(len), 5);
    n0 = wa.size();
    send_frame(16'h4444, 16'h0000, -1, 4'b0);
    chk("idle_nwr", 32'(wa.size() - n0), 0);
    pulse(4'b0001);
    send_frame(16'hBEEF, 16'h0000, -1, 4'b0);
    chk("restart_addr", 32'(wa[wa.size()-1]), 0);
    chk("restart_data", 32'(wd[wd.size()-1]), 32'hBEEF);
    chk("restart_len", 32'(len), 1);
    n0 = wa.size();
    send_frame(16'hCAFE, 16'h0000, 5, 4'b0110);
    chk("stoppause_rec", 32'(rec), 0);
    chk("stoppause_len", 32'(len), 1);
    send_frame(16'hCAFE, 16'h0000, -1, 4'b0);
    chk("stoppause_nwr", 32'(wa.size() - n0), 0);
    @(negedge clk);
    start2 = 1;
    @(negedge clk);
    start2 = 0;
    for (int i = 0; i < 4; i++) send_frame(16'h1000 + 16'(i), 16'hFFFF, -1, 4'b0);
    chk("max_nwr", 32'(wa2.size()), 4);
    for (int i = 0; i < 4 && i < wa2.size(); i++) begin
      chk($sformatf("max_addr%0d", i), 32'(wa2[i]), 32'(i));
      chk($sformatf("max_data%0d", i), 32'(wd2[i]), 32'h1000 + 32'(i));
    end
    chk("max_full", 32'(full2), 1);
    chk("max_rec", 32'(rec2), 0);
    chk("max_len", 32'(len2), 4);
    send_frame(16'h1004, 16'hFFFF, -1, 4'b0);
    chk("max_fifth_nwr", 32'(wa2.size()), 4);
    chk("not_full", 32'(full), 0);
    pulse(4'b0001);
    n0 = wa.size();
    send_frame(16'h3C3C, 16'h0000, 8, 4'b1000);
    send_frame(16'h3C3C, 16'h0000, -1, 4'b0);
    chk("rst_nwr", 32'(wa.size() - n0), 0);
    chk("rst_idle", 32'(rec), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
